// File: rtl/shift_seq_rev.sv
// Sequential shifter that works one bit per clock: logical right or rotate left.
// Illegal modes and zero counts finish straight from IDLE with the operand unchanged.
module shift_seq_rev (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] in,
    input  logic [3:0]  amount,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic [15:0] out,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] work_reg, work_next;
    logic [3:0]  count_reg, count_next;
    logic [1:0]  mode_reg, mode_next;
    logic [15:0] out_reg, out_next;
    logic        err_reg, err_next;
    logic [15:0] step_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            work_reg  <= 16'h0000;
            count_reg <= 4'd0;
            mode_reg  <= 2'b00;
            out_reg   <= 16'h0000;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            count_reg <= count_next;
            mode_reg  <= mode_next;
            out_reg   <= out_next;
            err_reg   <= err_next;
        end
    end

    // One-bit step of the captured operation; illegal codes never reach SHIFT.
    always_comb begin
        case (mode_reg)
            2'b00:   step_value = {1'b0, work_reg[15:1]};
            2'b01:   step_value = {work_reg[14:0], work_reg[15]};
            default: step_value = work_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        count_next = count_reg;
        mode_next  = mode_reg;
        out_next   = out_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    work_next  = in;
                    count_next = amount;
                    mode_next  = mode;
                    if (mode[1]) begin
                        state_next = DONE;
                        out_next   = in;
                        err_next   = 1'b1;
                    end else if (amount == 4'd0) begin
                        state_next = DONE;
                        out_next   = in;
                        err_next   = 1'b0;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_next  = step_value;
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    state_next = DONE;
                    out_next   = step_value;
                    err_next   = 1'b0;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == SHIFT);
    assign done = (state_reg == DONE);
    assign out  = out_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_shift_seq_rev.sv
// Self-checking bench for shift_seq_rev: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_shift_seq_rev;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] din;
    logic [3:0]  amt;
    logic [1:0]  md;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        err;

    int          checks;
    int          errors;
    logic [15:0] prev_out;
    logic        prev_err;

    shift_seq_rev dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .in     (din),
        .amount (amt),
        .mode   (md),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-word arithmetic, no stepping.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] n, input logic [1:0] m);
        logic [31:0] dbl;
        if (m[1]) return a;
        if (m == 2'b00) return a >> n;
        dbl = {a, a} << n;
        return dbl[31:16];
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        din   = 16'h0;
        amt   = 4'd0;
        md    = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: busy=%b done=%b out=%h err=%b, required 0 0 0000 0", busy, done, out, err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_out = 16'h0000;
        prev_err = 1'b0;
        $display("reset: busy=%b done=%b out=%h err=%b", busy, done, out, err);
    endtask

    // Caller must be ~1ns after a rising edge with the DUT in IDLE.
    task automatic run_op(input logic [15:0] a, input logic [3:0] n, input logic [1:0] m,
                          input bit poke, input string tag);
        logic [15:0] eo;
        logic        ee;
        int          kexp;
        int          k;
        int          busy_cnt;
        eo   = model(a, n, m);
        ee   = m[1];
        kexp = (!m[1] && n != 4'd0) ? int'(n) : 0;
        start = 1'b1; din = a; amt = n; md = m;
        @(posedge clk); #1;
        start = 1'b0; din = 16'($urandom); amt = 4'($urandom); md = 2'($urandom);
        k = 0; busy_cnt = 0;
        while (done !== 1'b1 && k < 40) begin
            if (busy === 1'b1) busy_cnt++;
            checks++;
            if (out !== prev_out || err !== prev_err) begin
                errors++;
                $display("FAIL %s_hold: out=%h err=%b at k=%0d, required %h %b", tag, out, err, k, prev_out, prev_err);
            end
            if (poke && k == 1) begin
                start = 1'b1; din = ~a; amt = 4'd1; md = {1'b0, ~m[0]};
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || k !== kexp || busy_cnt !== kexp) begin
            errors++;
            $display("FAIL %s_timing: done=%b latency=%0d busy_cycles=%0d, required 1 %0d %0d", tag, done, k, busy_cnt, kexp, kexp);
        end
        checks++;
        if (out !== eo || err !== ee) begin
            errors++;
            $display("FAIL %s_result: out=%h err=%b, required out=%h err=%b", tag, out, err, eo, ee);
        end
        $display("op %s: in=%h amount=%0d mode=%b -> out=%h err=%b latency=%0d", tag, a, n, m, out, err, k);
        prev_out = eo;
        prev_err = ee;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out !== eo || err !== ee) begin
            errors++;
            $display("FAIL %s_after: done=%b busy=%b out=%h err=%b, required 0 0 %h %b", tag, done, busy, out, err, eo, ee);
        end
    endtask

    task automatic test_directed();
        run_op(16'h8001, 4'd4,  2'b00, 1'b0, "lsr_8001_4");
        run_op(16'h8001, 4'd15, 2'b01, 1'b0, "rotl_8001_15");
        run_op(16'h1234, 4'd0,  2'b01, 1'b0, "zero_count");
        checks++;
        if (prev_out !== 16'h1234) begin
            errors++;
            $display("FAIL zero_model: got %h, required 1234", prev_out);
        end
    endtask

    task automatic test_illegal();
        run_op(16'hBEEF, 4'd7, 2'b10, 1'b0, "illegal_10");
        run_op(16'h1234, 4'd3, 2'b00, 1'b0, "legal_after_illegal");
        run_op(16'hCAFE, 4'd2, 2'b11, 1'b0, "illegal_11");
    endtask

    task automatic test_start_while_busy();
        run_op(16'hA5C3, 4'd4, 2'b01, 1'b1, "poke_during_busy");
    endtask

    task automatic test_back_to_back();
        logic [15:0] a1, a2;
        logic [3:0]  n1, n2;
        logic [1:0]  m1, m2;
        int          k;
        a1 = 16'($urandom); n1 = 4'($urandom_range(1, 15)); m1 = 2'($urandom_range(0, 1));
        a2 = 16'($urandom); n2 = 4'($urandom_range(1, 15)); m2 = 2'($urandom_range(0, 1));
        start = 1'b1; din = a1; amt = n1; md = m1;
        @(posedge clk); #1;
        din = a2; amt = n2; md = m2;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (k !== int'(n1) || out !== model(a1, n1, m1) || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: latency=%0d out=%h err=%b, required %0d %h 0", k, out, err, n1, model(a1, n1, m1));
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b, required 0 0", busy, done);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reaccept: busy=%b, required 1", busy);
        end
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (k !== int'(n2) || out !== model(a2, n2, m2) || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: latency=%0d out=%h err=%b, required %0d %h 0", k, out, err, n2, model(a2, n2, m2));
        end
        $display("b2b: first %h/%0d/%b then %h/%0d/%b -> out=%h", a1, n1, m1, a2, n2, m2, out);
        prev_out = model(a2, n2, m2);
        prev_err = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int seen_done;
        start = 1'b1; din = 16'h1357; amt = 4'd9; md = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy: busy=%b, required 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: busy=%b done=%b out=%h err=%b, required 0 0 0000 0", busy, done, out, err);
        end
        seen_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            if (done !== 1'b0) seen_done++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL rst_mid_no_done: %0d bad cycles, required 0", seen_done);
        end
        $display("reset mid-op: outputs cleared, out=%h", out);
        prev_out = 16'h0000;
        prev_err = 1'b0;
        rst_n = 1'b0;
        #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(16'hF00F, 4'd8, 2'b00, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), 4'($urandom), 2'($urandom), bit'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_illegal();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
